decode_bundle_sender: RTL

// - Producer side of the decode -> instruction-buffer write interface: queues decoded fetch bundles and

---
 rtl/fe_pkg.sv | 15 +
 rtl/decode_bundle_sender_if.sv | 21 ++
 rtl/bundle_compactor.sv | 25 ++
 rtl/decode_bundle_sender.sv | 60 ++++++
 4 files changed

// File: rtl/fe_pkg.sv
// fe_pkg: front-end constants and the decoded-bundle type shared by Decode and the instruction buffer.
package fe_pkg;
  localparam int DEC_PKT_W = 32;
  localparam int FETCH_WIDTH = 8;
  localparam int CTI_OFS = 28;
  typedef struct packed {
    logic [FETCH_WIDTH-1:0] vector;
    logic [FETCH_WIDTH*DEC_PKT_W-1:0] pkts;
  } dec_bundle_t;
  function automatic logic isContiguous(input logic [FETCH_WIDTH-1:0] v);
    logic [FETCH_WIDTH-1:0] vp;
    vp = v + 1'b1;
    return ~|(v & vp);
  endfunction
endpackage

// File: rtl/decode_bundle_sender_if.sv
// decode_bundle_sender_if: Decode-side bundle handshake plus instruction-buffer write port.
interface decode_bundle_sender_if #(
    parameter int FETCH_WIDTH = fe_pkg::FETCH_WIDTH,
    parameter int PKT_W = fe_pkg::DEC_PKT_W,
    parameter int DEPTH = 2
);
    logic flush_i;
    logic bundle_valid_i;
    logic [FETCH_WIDTH-1:0] bundle_vector_i;
    logic [FETCH_WIDTH*PKT_W-1:0] bundle_pkts_i;
    logic bundle_ready_o;
    logic stall_fetch_i;
    logic decode_ready_o;
    logic [FETCH_WIDTH-1:0] decoded_vector_o;
    logic [FETCH_WIDTH*PKT_W-1:0] decoded_pkts_o;
    logic [$clog2(DEPTH):0] occupancy_o;
    modport master(output flush_i, bundle_valid_i, bundle_vector_i, bundle_pkts_i, stall_fetch_i,
                   input bundle_ready_o, decode_ready_o, decoded_vector_o, decoded_pkts_o, occupancy_o);
    modport slave(input flush_i, bundle_valid_i, bundle_vector_i, bundle_pkts_i, stall_fetch_i,
                  output bundle_ready_o, decode_ready_o, decoded_vector_o, decoded_pkts_o, occupancy_o);
endinterface

// File: rtl/bundle_compactor.sv
// bundle_compactor: packs valid lanes down to lanes 0..n-1 in ascending order.
module bundle_compactor #(
    parameter int FETCH_WIDTH = fe_pkg::FETCH_WIDTH,
    parameter int PKT_W = fe_pkg::DEC_PKT_W
) (
    input  logic [FETCH_WIDTH-1:0] inVector,
    input  logic [FETCH_WIDTH*PKT_W-1:0] inPkts,
    output logic [FETCH_WIDTH-1:0] outVector,
    output logic [FETCH_WIDTH*PKT_W-1:0] outPkts
);
    logic [$clog2(FETCH_WIDTH)-1:0] pos;
    // pos is the running prefix popcount: the output lane for the next valid input lane
    always_comb begin
        outVector = '0;
        outPkts = '0;
        pos = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (inVector[i]) begin
                outPkts[pos*PKT_W +: PKT_W] = inPkts[i*PKT_W +: PKT_W];
                outVector[pos] = 1'b1;
                pos = pos + 1'b1;
            end
        end
    end
endmodule

// File: rtl/decode_bundle_sender.sv
// decode_bundle_sender: skid queue of decoded bundles feeding the instruction buffer under stallFetch.
// Define DECODE_COMPACT_EN to compact sparse lane vectors on enqueue.
module decode_bundle_sender
    import fe_pkg::*;
#(
    parameter int FETCH_WIDTH = fe_pkg::FETCH_WIDTH,
    parameter int PKT_W = fe_pkg::DEC_PKT_W,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic reset,
    decode_bundle_sender_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] rdPtr, wrPtr;
    logic [PW:0] count;
    dec_bundle_t slots [DEPTH];
    dec_bundle_t inBundle, head;
    logic ready, nonEmpty, enq, deq;
`ifdef DECODE_COMPACT_EN
    bundle_compactor #(.FETCH_WIDTH(FETCH_WIDTH), .PKT_W(PKT_W)) compactor (
        .inVector(bus.bundle_vector_i),
        .inPkts(bus.bundle_pkts_i),
        .outVector(inBundle.vector),
        .outPkts(inBundle.pkts)
    );
`else
    assign inBundle.vector = bus.bundle_vector_i[FETCH_WIDTH-1:0];
    assign inBundle.pkts = bus.bundle_pkts_i[FETCH_WIDTH*PKT_W-1:0];
    assert property (@(posedge clk) disable iff (reset) enq |-> isContiguous(bus.bundle_vector_i));
`endif
    assign ready = count < (PW+1)'(DEPTH);
    assign nonEmpty = count != '0;
    assign enq = bus.bundle_valid_i & ready & |bus.bundle_vector_i & ~bus.flush_i;
    assign deq = nonEmpty & ~bus.stall_fetch_i;
    assign head = slots[rdPtr];
    assign bus.bundle_ready_o = ready;
    assign bus.decode_ready_o = nonEmpty;
    assign bus.decoded_vector_o = nonEmpty ? head.vector : '0;
    assign bus.decoded_pkts_o = head.pkts;
    assign bus.occupancy_o = count;
    // slots are cleared with the pointers so a flushed head never leaks onto the packet bus
    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else begin
            if (enq) begin
                slots[wrPtr] <= inBundle;
                wrPtr <= wrPtr + 1'b1;
            end
            if (deq) rdPtr <= rdPtr + 1'b1;
            count <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
        end
    end
    assert property (@(posedge clk) disable iff (reset)
        !(bus.bundle_valid_i && |bus.bundle_vector_i && !bus.flush_i && !ready));
endmodule
